// File: rtl/mixer_stream_ctrl.sv
// Streams samples from an input RAM into a mixer at a fixed issue rate and writes
// the mixer results to an output RAM, with drain timeout and sticky error reporting.
module mixer_stream_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_W:0]          len_i,
  input  logic signed [31:0]       delta_index_cfg_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     rd_en_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  input  logic signed [7:0]        rd_real_i,
  input  logic signed [7:0]        rd_imag_i,
  output logic signed [7:0]        mix_real_o,
  output logic signed [7:0]        mix_imag_o,
  output logic signed [31:0]       mix_delta_index_o,
  output logic                     mix_valid_o,
  input  logic signed [7:0]        mix_real_i,
  input  logic signed [7:0]        mix_imag_i,
  input  logic                     mix_valid_i,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic signed [7:0]        wr_real_o,
  output logic signed [7:0]        wr_imag_o
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] GapLast = 4'(GAP - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);
  localparam logic [IdleW-1:0] IdleOne = IdleW'(1);
  localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_W:0]         len_q, in_cnt_q, out_cnt_q;
  logic [3:0]              gap_q;
  logic [IdleW-1:0]        idle_q;
  logic                    rd_pend_q;
  logic                    busy_q, done_q, err_q;
  logic                    rd_en_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic signed [7:0]       mix_real_q, mix_imag_q;
  logic signed [31:0]      delta_q;
  logic                    mix_valid_q;
  logic                    wr_en_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic signed [7:0]       wr_real_q, wr_imag_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      gap_q       <= '0;
      idle_q      <= '0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      mix_real_q  <= '0;
      mix_imag_q  <= '0;
      delta_q     <= '0;
      mix_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_real_q   <= '0;
      wr_imag_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;

      // RAM data arrives one cycle after the read strobe; register it for the mixer.
      rd_pend_q   <= rd_en_q;
      mix_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        mix_real_q <= rd_real_i;
        mix_imag_q <= rd_imag_i;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q     <= len_i;
            delta_q   <= delta_index_cfg_i;
            err_q     <= 1'b0;
            out_cnt_q <= '0;
            gap_q     <= '0;
            idle_q    <= '0;
            if (len_i == '0) begin
              in_cnt_q <= '0;
              state_q  <= StDone;
              done_q   <= 1'b1;
            end else begin
              // First read goes out in the cycle right after the start is taken.
              in_cnt_q  <= CntOne;
              rd_en_q   <= 1'b1;
              rd_addr_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= StRun;
            end
          end
        end
        StRun: begin
          if (in_cnt_q == len_q) begin
            state_q <= StDrain;
            idle_q  <= '0;
          end else if (gap_q == GapLast) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= in_cnt_q[ADDR_W-1:0];
            in_cnt_q  <= in_cnt_q + CntOne;
            gap_q     <= '0;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        StDrain: begin
          if (out_cnt_q == len_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (mix_valid_i) begin
            idle_q <= '0;
          end else if (idle_q == IdleLast) begin
            err_q   <= 1'b1;
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idle_q <= idle_q + IdleOne;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Result path runs independently of reads; placed last so an error outranks the start clear.
      if (mix_valid_i) begin
        if ((state_q == StRun || state_q == StDrain) && (out_cnt_q < len_q)) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= out_cnt_q[ADDR_W-1:0];
          wr_real_q <= mix_real_i;
          wr_imag_q <= mix_imag_i;
          out_cnt_q <= out_cnt_q + CntOne;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign rd_en_o           = rd_en_q;
  assign rd_addr_o         = rd_addr_q;
  assign mix_real_o        = mix_real_q;
  assign mix_imag_o        = mix_imag_q;
  assign mix_delta_index_o = delta_q;
  assign mix_valid_o       = mix_valid_q;
  assign wr_en_o           = wr_en_q;
  assign wr_addr_o         = wr_addr_q;
  assign wr_real_o         = wr_real_q;
  assign wr_imag_o         = wr_imag_q;

endmodule

// File: tb/tb_mixer_stream_ctrl.sv
// Bench for mixer_stream_ctrl: RAM and echoing mixer models, event recorder and
// per-scenario checks against a schedule computed from the transfer rules.
module tb_mixer_stream_ctrl;
  localparam int AW  = 10;
  localparam int G   = 2;
  localparam int TO  = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic [AW:0] len_i = '0;
  logic signed [31:0] delta_i = '0;
  logic busy_o, done_o, err_o, rd_en_o, mix_valid_o, wr_en_o, mix_valid_i;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic signed [7:0] rd_real_i = '0, rd_imag_i = '0;
  logic signed [7:0] mix_real_o, mix_imag_o, mix_real_i, mix_imag_i, wr_real_o, wr_imag_o;
  logic signed [31:0] mix_delta_index_o;

  always #5 clk = ~clk;

  mixer_stream_ctrl #(.ADDR_W(AW), .GAP(G), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .delta_index_cfg_i(delta_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_real_i(rd_real_i), .rd_imag_i(rd_imag_i), .mix_real_o(mix_real_o),
    .mix_imag_o(mix_imag_o), .mix_delta_index_o(mix_delta_index_o), .mix_valid_o(mix_valid_o),
    .mix_real_i(mix_real_i), .mix_imag_i(mix_imag_i), .mix_valid_i(mix_valid_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_real_o(wr_real_o), .wr_imag_o(wr_imag_o)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Input sample RAM
  logic signed [7:0] ram_re [1<<AW];
  logic signed [7:0] ram_im [1<<AW];
  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_real_i <= ram_re[rd_addr_o];
      rd_imag_i <= ram_im[rd_addr_o];
    end
  end

  // Mixer model: echoes each strobe three cycles later; can drop one result by index
  logic [2:0] pv = '0;
  logic signed [7:0] pr [3];
  logic signed [7:0] pim [3];
  int mv_cnt = 0;
  int drop_idx = -1;
  logic force_v = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
      mv_cnt <= 0;
    end else begin
      pv <= {pv[1:0], mix_valid_o && (mv_cnt != drop_idx)};
      if (mix_valid_o) mv_cnt <= mv_cnt + 1;
    end
    pr[0] <= mix_real_o; pr[1] <= pr[0]; pr[2] <= pr[1];
    pim[0] <= mix_imag_o; pim[1] <= pim[0]; pim[2] <= pim[1];
  end
  assign mix_valid_i = pv[2] | force_v;
  assign mix_real_i  = pr[2];
  assign mix_imag_i  = pim[2];

  typedef struct {
    int cyc;
    int addr;
    logic [7:0] re;
    logic [7:0] im;
  } ev_t;
  ev_t rd_q[$], mv_q[$], wr_q[$];
  int done_q[$];
  int busy_cnt = 0;
  bit err_seen = 0;
  int err_cyc = 0;
  bit delta_bad = 0;
  bit hold_bad = 0;
  logic signed [31:0] exp_delta = '0;
  logic [7:0] last_re = '0, last_im = '0;

  // Recorder samples 1ns after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (rd_en_o) rd_q.push_back('{cyc, int'(rd_addr_o), 8'd0, 8'd0});
    if (mix_valid_o) mv_q.push_back('{cyc, 0, mix_real_o, mix_imag_o});
    if (wr_en_o) wr_q.push_back('{cyc, int'(wr_addr_o), wr_real_o, wr_imag_o});
    if (done_o) done_q.push_back(cyc);
    if (busy_o) busy_cnt++;
    if (err_o === 1'b1 && !err_seen) begin err_seen = 1; err_cyc = cyc; end
    if (busy_o && mix_delta_index_o !== exp_delta) delta_bad = 1;
    if (rst && !mix_valid_o && (mix_real_o !== last_re || mix_imag_o !== last_im)) hold_bad = 1;
    last_re = mix_real_o;
    last_im = mix_imag_o;
  end

  task automatic clear_log();
    rd_q.delete(); mv_q.delete(); wr_q.delete(); done_q.delete();
    busy_cnt = 0; err_seen = 0; delta_bad = 0; hold_bad = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0; force_v = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
    exp_delta = '0;
    clear_log();
  endtask

  task automatic fill_ram(input int n);
    for (int i = 0; i < n; i++) begin
      ram_re[i] = 8'($urandom);
      ram_im[i] = 8'($urandom);
    end
  endtask

  // Start is sampled at the end of cycle t0; inputs are scrambled afterwards to prove latching.
  task automatic start_xfer(input int len, input logic signed [31:0] d, output int t0);
    @(negedge clk);
    start_i = 1'b1; len_i = (AW+1)'(len); delta_i = d;
    t0 = cyc;
    clear_log();
    exp_delta = d;
    @(negedge clk);
    start_i = 1'b0; len_i = (AW+1)'($urandom); delta_i = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b1; len_i = 4; delta_i = 32'sd12345;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, err_o, rd_en_o, mix_valid_o, wr_en_o} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000",
               {busy_o, done_o, err_o, rd_en_o, mix_valid_o, wr_en_o});
    else n_pass++;
    n_checks++;
    if ({mix_delta_index_o, mix_real_o, mix_imag_o, rd_addr_o, wr_addr_o, wr_real_o, wr_imag_o}
        !== '0)
      $display("FAIL reset_data: delta %0d mix %0d/%0d want all 0", mix_delta_index_o,
               mix_real_o, mix_imag_o);
    else n_pass++;
    n_checks++;
    if (rd_q.size() != 0) $display("FAIL reset_no_read: got %0d reads want 0", rd_q.size());
    else n_pass++;
    start_i = 1'b0; rst = 1'b1;
    clear_log();
  endtask

  task automatic test_basic();
    int t0;
    logic signed [31:0] d;
    d = -32'sd1048576000;
    fill_ram(4);
    start_xfer(4, d, t0);
    repeat (30) @(negedge clk);
    n_checks++;
    if (rd_q.size() != 4 || mv_q.size() != 4 || wr_q.size() != 4)
      $display("FAIL basic_counts: rd %0d mv %0d wr %0d want 4/4/4", rd_q.size(), mv_q.size(),
               wr_q.size());
    else n_pass++;
    for (int i = 0; i < rd_q.size() && i < 4; i++) begin
      n_checks++;
      if (rd_q[i].cyc != t0 + 1 + G*i || rd_q[i].addr != i)
        $display("FAIL basic_rd%0d: cyc %0d addr %0d want cyc %0d addr %0d", i,
                 rd_q[i].cyc - t0, rd_q[i].addr, 1 + G*i, i);
      else n_pass++;
    end
    for (int i = 0; i < mv_q.size() && i < 4; i++) begin
      n_checks++;
      if (mv_q[i].cyc != t0 + 3 + G*i || mv_q[i].re !== ram_re[i] || mv_q[i].im !== ram_im[i])
        $display("FAIL basic_mix%0d: cyc %0d data %0h/%0h want cyc %0d data %0h/%0h", i,
                 mv_q[i].cyc - t0, mv_q[i].re, mv_q[i].im, 3 + G*i, ram_re[i], ram_im[i]);
      else n_pass++;
    end
    for (int i = 0; i < wr_q.size() && i < 4; i++) begin
      n_checks++;
      if (wr_q[i].cyc != t0 + 7 + G*i || wr_q[i].addr != i || wr_q[i].re !== ram_re[i] ||
          wr_q[i].im !== ram_im[i])
        $display("FAIL basic_wr%0d: cyc %0d addr %0d data %0h/%0h want cyc %0d addr %0d %0h/%0h",
                 i, wr_q[i].cyc - t0, wr_q[i].addr, wr_q[i].re, wr_q[i].im, 7 + G*i, i,
                 ram_re[i], ram_im[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != t0 + 8 + G*3)
      $display("FAIL basic_done: %0d pulses first at %0d want 1 at %0d", done_q.size(),
               done_q.size() ? done_q[0] - t0 : -1, 8 + G*3);
    else n_pass++;
    n_checks++;
    if (busy_cnt != 7 + G*3) $display("FAIL basic_busy: got %0d cycles want %0d", busy_cnt, 7 + G*3);
    else n_pass++;
    n_checks++;
    if (err_seen || delta_bad || hold_bad || mix_delta_index_o !== d)
      $display("FAIL basic_flags: err %0d delta_bad %0d hold_bad %0d delta %0d want 0 0 0 %0d",
               err_seen, delta_bad, hold_bad, mix_delta_index_o, d);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int t0;
    start_xfer(0, 32'sd77, t0);
    repeat (12) @(negedge clk);
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != t0 + 1)
      $display("FAIL zero_done: %0d pulses first at %0d want 1 at 1", done_q.size(),
               done_q.size() ? done_q[0] - t0 : -1);
    else n_pass++;
    n_checks++;
    if (rd_q.size() + mv_q.size() + wr_q.size() + busy_cnt != 0 || err_seen)
      $display("FAIL zero_quiet: rd %0d mv %0d wr %0d busy %0d err %0d want all 0", rd_q.size(),
               mv_q.size(), wr_q.size(), busy_cnt, err_seen);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int t0;
    logic signed [31:0] d;
    d = $urandom;
    fill_ram(8);
    start_xfer(4, d, t0);
    @(negedge clk);
    start_i = 1'b1; len_i = 7; delta_i = ~d;
    @(negedge clk);
    start_i = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (rd_q.size() != 4 || wr_q.size() != 4 || done_q.size() != 1)
      $display("FAIL ignore_counts: rd %0d wr %0d done %0d want 4 4 1", rd_q.size(), wr_q.size(),
               done_q.size());
    else n_pass++;
    n_checks++;
    if (delta_bad || err_seen || mix_delta_index_o !== d)
      $display("FAIL ignore_latched: delta_bad %0d err %0d delta %0d want 0 0 %0d", delta_bad,
               err_seen, mix_delta_index_o, d);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int t0, exp_err;
    do_reset(2);
    drop_idx = 3;
    fill_ram(4);
    start_xfer(4, 32'sd5, t0);
    exp_err = t0 + 7 + G*2 + TO;
    repeat (TO + 30) @(negedge clk);
    drop_idx = -1;
    n_checks++;
    if (wr_q.size() != 3) $display("FAIL timeout_writes: got %0d want 3", wr_q.size());
    else n_pass++;
    n_checks++;
    if (!err_seen || err_cyc != exp_err)
      $display("FAIL timeout_err: seen %0d at %0d want 1 at %0d", err_seen, err_cyc - t0,
               exp_err - t0);
    else n_pass++;
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != exp_err)
      $display("FAIL timeout_done: %0d pulses first at %0d want 1 at %0d", done_q.size(),
               done_q.size() ? done_q[0] - t0 : -1, exp_err - t0);
    else n_pass++;
    n_checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL timeout_sticky: err %b busy %b want 1 0", err_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_idle_valid();
    do_reset(2);
    @(negedge clk);
    force_v = 1'b1;
    @(negedge clk);
    force_v = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_o !== 1'b1 || wr_q.size() != 0)
      $display("FAIL idle_valid: err %b writes %0d want 1 0", err_o, wr_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int t0, late;
    fill_ram(8);
    start_xfer(8, 32'sd999, t0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    late = 0;
    foreach (mv_q[i]) if (mv_q[i].cyc >= t0 + 4) late++;
    n_checks++;
    if (rd_q.size() != 2 || late != 0 || wr_q.size() != 0 || done_q.size() != 0)
      $display("FAIL abort_quiet: rd %0d late_mix %0d wr %0d done %0d want 2 0 0 0", rd_q.size(),
               late, wr_q.size(), done_q.size());
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || mix_delta_index_o !== '0)
      $display("FAIL abort_state: busy %b err %b delta %0d want 0 0 0", busy_o, err_o,
               mix_delta_index_o);
    else n_pass++;
    start_xfer(2, 32'sd3, t0);
    repeat (20) @(negedge clk);
    n_checks++;
    if (rd_q.size() != 2 || rd_q[0].cyc != t0 + 1 || wr_q.size() != 2)
      $display("FAIL abort_restart: rd %0d wr %0d first rd at %0d want 2 2 at 1", rd_q.size(),
               wr_q.size(), rd_q.size() ? rd_q[0].cyc - t0 : -1);
    else n_pass++;
  endtask

  task automatic test_back_to_back_random();
    int t0, len, bad;
    logic signed [31:0] d;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 24);
      d = $urandom;
      fill_ram(len);
      start_xfer(len, d, t0);
      for (int k = 0; k < G*len + 40 && done_q.size() == 0; k++) @(negedge clk);
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != t0 + 8 + G*(len - 1))
        $display("FAIL rand%0d_done: %0d pulses first at %0d want 1 at %0d", it, done_q.size(),
                 done_q.size() ? done_q[0] - t0 : -1, 8 + G*(len - 1));
      else n_pass++;
      bad = 0;
      foreach (rd_q[i]) if (rd_q[i].cyc != t0 + 1 + G*i || rd_q[i].addr != i) bad++;
      n_checks++;
      if (rd_q.size() != len || bad != 0)
        $display("FAIL rand%0d_reads: got %0d (%0d misplaced) want %0d", it, rd_q.size(), bad, len);
      else n_pass++;
      bad = 0;
      foreach (wr_q[i])
        if (wr_q[i].cyc != t0 + 7 + G*i || wr_q[i].addr != i || wr_q[i].re !== ram_re[i] ||
            wr_q[i].im !== ram_im[i]) bad++;
      n_checks++;
      if (wr_q.size() != len || bad != 0)
        $display("FAIL rand%0d_writes: got %0d (%0d wrong) want %0d", it, wr_q.size(), bad, len);
      else n_pass++;
      n_checks++;
      if (err_seen || delta_bad || hold_bad || mix_delta_index_o !== d)
        $display("FAIL rand%0d_flags: err %0d delta_bad %0d hold_bad %0d want 0 0 0", it, err_seen,
                 delta_bad, hold_bad);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_start_ignored();
    test_timeout();
    test_idle_valid();
    test_reset_abort();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mixer_stream_ctrl.md
MIXER_STREAM_CTRL -- requirements
Module: mixer_stream_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10: sample RAM address width.
REQ-002 The block SHALL have parameter GAP, default 2: cycles between consecutive sample issues, legal values 1 to 15.
REQ-003 The block SHALL have parameter TIMEOUT, default 255: maximum idle cycles without mix_valid_i while in DRAIN.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; ports are listed below with clock and reset first.
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start_i  in  1  start request, sampled in IDLE only
- len_i  in  ADDR_W+1  sample count, 0 to 2^ADDR_W
- delta_index_cfg_i  in  32 signed  NCO phase step, latched at start
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag
- rd_en_o / rd_addr_o  out  1 / ADDR_W  input sample RAM read port
- rd_real_i / rd_imag_i  in  8 signed each  RAM data, valid one cycle after rd_en_o
- mix_real_o / mix_imag_o  out  8 signed each  sample to mixer
- mix_delta_index_o  out  32 signed  mixer step
- mix_valid_o  out  1  mixer input strobe
- mix_real_i / mix_imag_i / mix_valid_i  in  8 / 8 / 1  mixer result
- wr_en_o / wr_addr_o / wr_real_o / wr_imag_o  out  1 / ADDR_W / 8 / 8  output RAM write port

Function
REQ-005 The FSM SHALL have exactly the states IDLE, RUN, DRAIN and DONE.
REQ-006 In IDLE, start_i=1 SHALL latch len_i and delta_index_cfg_i, clear err_o, clear the in and out counters, and go to RUN; if len_i=0 it SHALL go to DONE instead.
REQ-007 In RUN, rd_en_o SHALL pulse for one cycle with rd_addr_o = in_cnt: the first pulse in the first cycle after start is accepted, each later pulse exactly GAP cycles after the previous one; in_cnt increments per pulse.
REQ-008 Each read SHALL produce mix_valid_o for exactly one cycle, two cycles after the corresponding rd_en_o, with mix_real_o/mix_imag_o being the registered rd_real_i/rd_imag_i; those data outputs SHALL hold their value between strobes.
REQ-009 mix_delta_index_o SHALL equal the latched step and SHALL change only when a start is accepted.
REQ-010 After the len-th read is issued, the FSM SHALL go from RUN to DRAIN.
REQ-011 In RUN or DRAIN, mix_valid_i=1 with out_cnt<len SHALL produce, on the next cycle, wr_en_o=1 with wr_addr_o=out_cnt and wr_real_o/wr_imag_o equal to the registered mix_real_i/mix_imag_i; out_cnt then increments.
REQ-012 mix_valid_i=1 in IDLE or DONE, or with out_cnt=len, SHALL produce no write and SHALL set err_o.
REQ-013 DRAIN SHALL go to DONE in the cycle after the len-th write is issued; the len-th write may arrive while still in RUN.
REQ-014 In DRAIN, TIMEOUT consecutive cycles without mix_valid_i SHALL set err_o and force DONE; the idle counter resets on every mix_valid_i.
REQ-015 DONE SHALL last one cycle with done_o=1 and busy_o=0, then return to IDLE.
REQ-016 start_i outside IDLE SHALL be ignored, with no effect on counters, latched values or err_o.
REQ-017 A read and a write in the same cycle SHALL both proceed; the read and write ports are independent.

Reset
REQ-018 While rst=0 at a clock edge, the state SHALL become IDLE and all outputs, counters and latched values SHALL become 0, including err_o and mix_delta_index_o.
REQ-019 Reset asserted mid-RUN or mid-DRAIN SHALL abort the transfer immediately, with no further rd_en_o, mix_valid_o or wr_en_o after the reset edge.

Verification
REQ-020 The bench SHALL cover: rst=0 for 3 cycles with start_i=1 -> all outputs 0, no rd_en_o.
REQ-021 The bench SHALL cover: len=4, GAP=2, delta=-(250<<22), mixer model echoes data with latency 3 -> rd_addr 0,1,2,3 issued at cycles 1,3,5,7 after start; mix_valid_o at cycles 3,5,7,9; wr_addr 0 to 3 carry the echoed data; one done_o pulse; mix_delta_index_o constant; err_o=0.
REQ-022 The bench SHALL cover: len=0 -> done_o=1 one cycle after start; no rd_en_o, mix_valid_o or wr_en_o.
REQ-023 The bench SHALL cover: start_i pulsed during RUN with len_i=7 -> ignored; exactly 4 reads and 4 writes occur.
REQ-024 The bench SHALL cover: len=4 with the model dropping its last result -> err_o=1 TIMEOUT cycles after the 3rd write; done_o pulse; exactly 3 writes.
REQ-025 The bench SHALL cover: mix_valid_i pulsed in IDLE -> err_o=1 and no wr_en_o; reset asserted after the 2nd read of len=8 -> IDLE, with no activity until the next start.
